execute: RTL and testbench

Execute stage of the fewcore pipeline, sitting directly upstream of the write stage. Each cycle it accepts one decoded instruction with its operands, computes the ALU result or the memory address, and registers everything the write stage consumes. An optional iterative multiply/divide unit stalls decode through a ready/valid handshake while it runs.

---
 rtl/execute.sv | 321 ++++++++++++++++++++++++++++++++
 tb/tb_execute.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute.sv
// Execute stage of the fewcore pipeline: ALU / effective-address generation with registered outputs.
// Define EXECUTE_MULDIV_EN to compile in the iterative multiply/divide unit and its IDLE/BUSY/DONE FSM.
module execute (
  input  logic        clk,
  input  logic        rst,
  input  logic        inValid,
  output logic        inReady,
  input  logic [11:0] code,
  input  logic [31:0] rs1Data,
  input  logic [31:0] rs2Data,
  input  logic [31:0] imm,
  input  logic [31:0] pc,
  input  logic [4:0]  rd,
  output logic        outValid,
  output logic [11:0] outCode,
  output logic [4:0]  outRd,
  output logic [31:0] dataAlu,
  output logic [31:0] memAddress,
  output logic        writeEnable,
  output logic        regWrite
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic        w_alt;
  logic        w_muldiv_enc;
  logic        w_accept;
  logic [31:0] w_opb;
  logic [4:0]  w_shamt;
  logic        w_slt;
  logic        w_sltu;
  logic [31:0] w_sra;
  logic [31:0] w_alu;
  logic [31:0] w_mem_addr;
  logic [31:0] w_res_data;
  logic [31:0] w_res_addr;
  logic        w_res_rw;
  logic        w_res_we;
  logic        w_start_md;
  logic        w_md_done;
  logic [31:0] w_md_result;
  logic [11:0] w_md_code;
  logic [4:0]  w_md_rd;

  assign w_opcode     = code[6:0];
  assign w_funct3     = code[9:7];
  assign w_alt        = code[11];
  assign w_muldiv_enc = (w_opcode == OPC_OP) & code[10];
  assign w_accept     = inValid & inReady;

  // OP-IMM takes its shift amount from imm[4:0], which is exactly the low bits of operand B.
  assign w_opb      = (w_opcode == OPC_OP) ? rs2Data : imm;
  assign w_shamt    = w_opb[4:0];
  assign w_slt      = $signed(rs1Data) < $signed(w_opb);
  assign w_sltu     = rs1Data < w_opb;
  assign w_sra      = $signed(rs1Data) >>> w_shamt;
  assign w_mem_addr = rs1Data + imm;

  // ALU operation select; funct7[5] only selects SUB for register-register ops.
  always_comb begin
    w_alu = 32'd0;
    case (w_funct3)
      3'd0: begin
        if ((w_opcode == OPC_OP) && w_alt) begin
          w_alu = rs1Data - w_opb;
        end else begin
          w_alu = rs1Data + w_opb;
        end
      end
      3'd1: w_alu = rs1Data << w_shamt;
      3'd2: w_alu = {31'd0, w_slt};
      3'd3: w_alu = {31'd0, w_sltu};
      3'd4: w_alu = rs1Data ^ w_opb;
      3'd5: begin
        if (w_alt) begin
          w_alu = w_sra;
        end else begin
          w_alu = rs1Data >> w_shamt;
        end
      end
      3'd6: w_alu = rs1Data | w_opb;
      3'd7: w_alu = rs1Data & w_opb;
      default: w_alu = 32'd0;
    endcase
  end

  // Result bundle for single-cycle instructions; unknown opcodes fall through as a bubble.
  always_comb begin
    w_res_data = 32'd0;
    w_res_addr = 32'd0;
    w_res_rw   = 1'b0;
    w_res_we   = 1'b0;
    case (w_opcode)
      OPC_OP: begin
        if (w_muldiv_enc) begin
          w_res_rw = 1'b0;
        end else begin
          w_res_data = w_alu;
          w_res_rw   = 1'b1;
        end
      end
      OPC_OPIMM: begin
        w_res_data = w_alu;
        w_res_rw   = 1'b1;
      end
      OPC_LUI: begin
        w_res_data = imm;
        w_res_rw   = 1'b1;
      end
      OPC_AUIPC: begin
        w_res_data = pc + imm;
        w_res_rw   = 1'b1;
      end
      OPC_LOAD: begin
        w_res_addr = w_mem_addr;
        w_res_rw   = 1'b1;
      end
      OPC_STORE: begin
        w_res_addr = w_mem_addr;
        w_res_data = rs2Data;
        w_res_we   = 1'b1;
      end
      default: w_res_data = 32'd0;
    endcase
  end

`ifdef EXECUTE_MULDIV_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        w_idle_ready;
  logic [5:0]  r_count;
  logic [2:0]  r_md_f3;
  logic [4:0]  r_md_rd;
  logic [11:0] r_md_code;
  logic [31:0] r_md_hi;
  logic [31:0] r_md_lo;
  logic [31:0] r_md_cand;
  logic        r_md_neg_p;
  logic        r_md_neg_r;
  logic        w_a_signed;
  logic        w_b_signed;
  logic        w_neg_a;
  logic        w_neg_b;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic        w_neg_p;
  logic [32:0] w_mul_sum;
  logic [32:0] w_div_top;
  logic        w_div_ge;
  logic [31:0] w_div_diff;
  logic [63:0] w_md_prod;

  assign w_idle_ready = (r_state == S_IDLE);
  assign inReady      = w_idle_ready & ~rst;
  assign w_start_md   = w_accept & w_muldiv_enc;
  assign w_md_done    = (r_state == S_DONE);
  assign w_md_code    = r_md_code;
  assign w_md_rd      = r_md_rd;

  // Operand signedness by funct3: MULH, MULHSU, DIV, REM treat rs1 as signed; MULH, DIV, REM also rs2.
  always_comb begin
    w_a_signed = 1'b0;
    w_b_signed = 1'b0;
    case (w_funct3)
      3'd1, 3'd4, 3'd6: begin
        w_a_signed = 1'b1;
        w_b_signed = 1'b1;
      end
      3'd2: w_a_signed = 1'b1;
      default: w_a_signed = 1'b0;
    endcase
  end

  assign w_neg_a = w_a_signed & rs1Data[31];
  assign w_neg_b = w_b_signed & rs2Data[31];
  assign w_abs_a = w_neg_a ? (32'd0 - rs1Data) : rs1Data;
  assign w_abs_b = w_neg_b ? (32'd0 - rs2Data) : rs2Data;
  // Division by zero keeps the all-ones quotient unsigned; the remainder always follows the dividend sign.
  assign w_neg_p = w_funct3[2] ? ((w_neg_a ^ w_neg_b) & (|rs2Data)) : (w_neg_a ^ w_neg_b);

  assign w_mul_sum  = {1'b0, r_md_hi} + (r_md_lo[0] ? {1'b0, r_md_cand} : 33'd0);
  assign w_div_top  = {r_md_hi, r_md_lo[31]};
  assign w_div_ge   = w_div_top >= {1'b0, r_md_cand};
  assign w_div_diff = w_div_top[31:0] - r_md_cand;
  assign w_md_prod  = r_md_neg_p ? (64'd0 - {r_md_hi, r_md_lo}) : {r_md_hi, r_md_lo};

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_md) begin
          w_state_next = S_BUSY;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_BUSY: begin
        if (r_count == 6'd1) begin
          w_state_next = S_DONE;
        end else begin
          w_state_next = S_BUSY;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Iterative datapath: {hi,lo} holds product or {remainder,quotient} on unsigned magnitudes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count    <= 6'd0;
      r_md_f3    <= 3'd0;
      r_md_rd    <= 5'd0;
      r_md_code  <= 12'd0;
      r_md_hi    <= 32'd0;
      r_md_lo    <= 32'd0;
      r_md_cand  <= 32'd0;
      r_md_neg_p <= 1'b0;
      r_md_neg_r <= 1'b0;
    end else if (w_start_md) begin
      r_count    <= 6'd32;
      r_md_f3    <= w_funct3;
      r_md_rd    <= rd;
      r_md_code  <= code;
      r_md_hi    <= 32'd0;
      r_md_lo    <= w_abs_a;
      r_md_cand  <= w_abs_b;
      r_md_neg_p <= w_neg_p;
      r_md_neg_r <= w_neg_a;
    end else if (r_state == S_BUSY) begin
      r_count <= r_count - 6'd1;
      if (r_md_f3[2]) begin
        r_md_hi <= w_div_ge ? w_div_diff : w_div_top[31:0];
        r_md_lo <= {r_md_lo[30:0], w_div_ge};
      end else begin
        r_md_hi <= w_mul_sum[32:1];
        r_md_lo <= {w_mul_sum[0], r_md_lo[31:1]};
      end
    end else begin
      r_count <= r_count;
    end
  end

  // Final result selection with sign fix-up.
  always_comb begin
    w_md_result = 32'd0;
    case (r_md_f3)
      3'd0:             w_md_result = w_md_prod[31:0];
      3'd1, 3'd2, 3'd3: w_md_result = w_md_prod[63:32];
      3'd4, 3'd5:       w_md_result = r_md_neg_p ? (32'd0 - r_md_lo) : r_md_lo;
      3'd6, 3'd7:       w_md_result = r_md_neg_r ? (32'd0 - r_md_hi) : r_md_hi;
      default:          w_md_result = 32'd0;
    endcase
  end
`else
  assign inReady     = ~rst;
  assign w_start_md  = 1'b0;
  assign w_md_done   = 1'b0;
  assign w_md_result = 32'd0;
  assign w_md_code   = 12'd0;
  assign w_md_rd     = 5'd0;
`endif

  // Output bundle register; payload holds its last value on idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      outValid    <= 1'b0;
      outCode     <= 12'd0;
      outRd       <= 5'd0;
      dataAlu     <= 32'd0;
      memAddress  <= 32'd0;
      writeEnable <= 1'b0;
      regWrite    <= 1'b0;
    end else if (w_md_done) begin
      outValid    <= 1'b1;
      outCode     <= w_md_code;
      outRd       <= w_md_rd;
      dataAlu     <= w_md_result;
      memAddress  <= 32'd0;
      writeEnable <= 1'b0;
      regWrite    <= 1'b1;
    end else if (w_accept && !w_start_md) begin
      outValid    <= 1'b1;
      outCode     <= code;
      outRd       <= rd;
      dataAlu     <= w_res_data;
      memAddress  <= w_res_addr;
      writeEnable <= w_res_we;
      regWrite    <= w_res_rw;
    end else begin
      outValid    <= 1'b0;
      writeEnable <= 1'b0;
      regWrite    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_execute.sv
// Self-checking bench for execute: arithmetic reference model plus directed vectors with literal expectations.
module tb_execute;
  localparam logic [6:0] OP    = 7'b0110011;
  localparam logic [6:0] OPIMM = 7'b0010011;

  logic clk = 1'b0;
  logic rst, inValid, inReady;
  logic [11:0] code;
  logic [31:0] rs1Data, rs2Data, imm, pc;
  logic [4:0] rd;
  logic outValid, writeEnable, regWrite;
  logic [11:0] outCode;
  logic [4:0] outRd;
  logic [31:0] dataAlu, memAddress;

  execute dut (
    .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady), .code(code),
    .rs1Data(rs1Data), .rs2Data(rs2Data), .imm(imm), .pc(pc), .rd(rd),
    .outValid(outValid), .outCode(outCode), .outRd(outRd), .dataAlu(dataAlu),
    .memAddress(memAddress), .writeEnable(writeEnable), .regWrite(regWrite)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [11:0] c;
    logic [4:0]  r;
    logic [31:0] data;
    logic [31:0] addr;
    logic        rw;
    logic        we;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_until = 0;
  logic started = 1'b0;
  logic rst_edge = 1'b0;
  logic [31:0] last_data = 32'd0, last_addr = 32'd0;
  logic [4:0] last_rd = 5'd0;
  logic [31:0] cap_data = 32'd0, cap_addr = 32'd0;
  logic cap_rw = 1'b0, cap_we = 1'b0;
  logic [4:0] cap_rd = 5'd0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h cycle=%0d", name, got, want, cyc);
    end
  endtask

  function automatic logic [11:0] enc(input logic alt, input logic m, input logic [2:0] f3, input logic [6:0] opc);
    return {alt, m, f3, opc};
  endfunction

  function automatic logic [31:0] muldiv(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sub;
    logic [63:0] ua, ub, pr;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    sub = ub;
    case (f3)
      3'd0: begin pr = ua * ub; return pr[31:0]; end
      3'd1: begin pr = sa * sb; return pr[63:32]; end
      3'd2: begin pr = sa * sub; return pr[63:32]; end
      3'd3: begin pr = ua * ub; return pr[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return 32'($signed(a) / $signed(b));
      end
      3'd5: return (b == 32'd0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        return 32'($signed(a) % $signed(b));
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic exp_t model(input logic [11:0] c, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] i, input logic [31:0] p, input logic [4:0] r,
                                 output logic md);
    exp_t x;
    logic [31:0] y;
    logic [63:0] wide;
    int sh;
    x.due = 0; x.c = c; x.r = r; x.data = 32'd0; x.addr = 32'd0; x.rw = 1'b0; x.we = 1'b0;
    md = 1'b0;
    if (c[6:0] == OP && c[10]) begin
`ifdef EXECUTE_MULDIV_EN
      md = 1'b1;
      x.rw = 1'b1;
      x.data = muldiv(c[9:7], a, b);
`endif
    end else if (c[6:0] == OP || c[6:0] == OPIMM) begin
      y = (c[6:0] == OP) ? b : i;
      sh = int'(y % 32'd32);
      x.rw = 1'b1;
      case (c[9:7])
        3'd0: x.data = (c[6:0] == OP && c[11]) ? a - y : a + y;
        3'd1: x.data = a * (32'd1 << sh);
        3'd2: x.data = ($signed(a) < $signed(y)) ? 32'd1 : 32'd0;
        3'd3: x.data = (a < y) ? 32'd1 : 32'd0;
        3'd4: x.data = a ^ y;
        3'd5: begin
          wide = c[11] ? {{32{a[31]}}, a} : {32'd0, a};
          wide = wide >> sh;
          x.data = wide[31:0];
        end
        3'd6: x.data = a | y;
        default: x.data = a & y;
      endcase
    end else if (c[6:0] == 7'b0110111) begin
      x.data = i; x.rw = 1'b1;
    end else if (c[6:0] == 7'b0010111) begin
      x.data = p + i; x.rw = 1'b1;
    end else if (c[6:0] == 7'b0000011) begin
      x.addr = a + i; x.rw = 1'b1;
    end else if (c[6:0] == 7'b0100011) begin
      x.addr = a + i; x.data = b; x.we = 1'b1;
    end
    return x;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rst_edge <= rst;
    started <= 1'b1;
  end

  // Compare process: every cycle, outputs against the model queue or the idle/hold rules.
  always @(negedge clk) begin
    if (started) begin
      if (rst_edge) begin
        chk("rst_valid", outValid, 0);
        chk("rst_ready", inReady, !rst);
        chk("rst_rw", regWrite, 0);
        chk("rst_we", writeEnable, 0);
        chk("rst_data", dataAlu, 0);
        chk("rst_addr", memAddress, 0);
        chk("rst_rd", outRd, 0);
        chk("rst_code", outCode, 0);
        last_data = 32'd0; last_addr = 32'd0; last_rd = 5'd0;
      end else begin
        chk("ready", inReady, (!rst && cyc >= busy_until) ? 1 : 0);
        while (q.size() > 0 && q[0].due < cyc) begin
          checks++; errors++;
          $display("FAIL missed_result due=%0d now=%0d", q[0].due, cyc);
          void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].due == cyc) begin
          e = q.pop_front();
          chk("valid", outValid, 1);
          chk("code", outCode, e.c);
          chk("rd", outRd, e.r);
          chk("data", dataAlu, e.data);
          chk("addr", memAddress, e.addr);
          chk("regwrite", regWrite, e.rw);
          chk("writeen", writeEnable, e.we);
          last_data = e.data; last_addr = e.addr; last_rd = e.r;
          cap_data = dataAlu; cap_addr = memAddress; cap_rw = regWrite; cap_we = writeEnable; cap_rd = outRd;
        end else begin
          chk("idle_valid", outValid, 0);
          chk("idle_rw", regWrite, 0);
          chk("idle_we", writeEnable, 0);
          chk("hold_data", dataAlu, last_data);
          chk("hold_addr", memAddress, last_addr);
          chk("hold_rd", outRd, last_rd);
        end
      end
    end
  end

  task automatic send(input logic [11:0] c, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] i, input logic [31:0] p, input logic [4:0] r);
    exp_t x;
    logic md;
    code = c; rs1Data = a; rs2Data = b; imm = i; pc = p; rd = r; inValid = 1'b1;
    @(posedge clk);
    #1;
    x = model(c, a, b, i, p, r, md);
    x.due = md ? cyc + 33 : cyc;
    if (md) busy_until = cyc + 33;
    q.push_back(x);
    inValid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    inValid = 1'b0;
    while (q.size() > 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (q.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout pending=%0d", q.size());
      q.delete();
    end
  endtask

  task automatic idle(input int n);
    inValid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; inValid = 1'b0; code = 12'd0; rs1Data = 32'd0; rs2Data = 32'd0;
    imm = 32'd0; pc = 32'd0; rd = 5'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset held 3 cycles while a MUL is in flight
    send(enc(1'b0, 1'b1, 3'd0, OP), 32'd3, 32'd5, 32'd0, 32'd0, 5'd1);
    idle(3);
    rst = 1'b1; q.delete(); busy_until = 0;
    idle(3);
    rst = 1'b0;
    send(enc(1'b0, 1'b0, 3'd0, OP), 32'd1, 32'd2, 32'd0, 32'd0, 5'd2);
    drain();
    chk("post_rst_add", cap_data, 32'd3);
    idle(40);

    send(enc(1'b0, 1'b0, 3'd0, OP), 32'h7FFFFFFF, 32'd1, 32'd0, 32'd0, 5'd5);
    drain();
    chk("add_ovf", cap_data, 32'h80000000);
    chk("add_rw", cap_rw, 1);
    chk("add_rd", cap_rd, 5);
    send(enc(1'b1, 1'b0, 3'd0, OP), 32'd0, 32'd1, 32'd0, 32'd0, 5'd6);
    drain();
    chk("sub_wrap", cap_data, 32'hFFFFFFFF);
    send(enc(1'b1, 1'b0, 3'd5, OP), 32'h80000000, 32'd31, 32'd0, 32'd0, 5'd7);
    drain();
    chk("sra31", cap_data, 32'hFFFFFFFF);
    send(enc(1'b0, 1'b0, 3'd2, 7'b0100011), 32'h100, 32'hDEADBEEF, 32'hFFFFFFFC, 32'd0, 5'd8);
    drain();
    chk("store_addr", cap_addr, 32'hFC);
    chk("store_data", cap_data, 32'hDEADBEEF);
    chk("store_we", cap_we, 1);
    chk("store_rw", cap_rw, 0);
    send(enc(1'b0, 1'b0, 3'd2, OP), 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 5'd9);
    drain();
    chk("slt_neg", cap_data, 32'd1);
    send(enc(1'b0, 1'b0, 3'd0, 7'b1111111), 32'd5, 32'd6, 32'd7, 32'd0, 5'd10);
    drain();
    chk("bubble_rw", cap_rw, 0);
    chk("bubble_data", cap_data, 32'd0);

    // model-only coverage, issued back to back
    send(enc(1'b0, 1'b0, 3'd1, OP), 32'h12345678, 32'h00000024, 32'd0, 32'd0, 5'd11);
    send(enc(1'b0, 1'b0, 3'd3, OP), 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 5'd12);
    send(enc(1'b0, 1'b0, 3'd4, OP), 32'hF0F0F0F0, 32'h0FF00FF0, 32'd0, 32'd0, 5'd13);
    send(enc(1'b0, 1'b0, 3'd5, OP), 32'h80000000, 32'd35, 32'd0, 32'd0, 5'd14);
    send(enc(1'b0, 1'b0, 3'd6, OP), 32'hA0000005, 32'h0000000A, 32'd0, 32'd0, 5'd15);
    send(enc(1'b0, 1'b0, 3'd7, OP), 32'hFF00FF00, 32'h0F0F0F0F, 32'd0, 32'd0, 5'd16);
    send(enc(1'b1, 1'b0, 3'd0, OPIMM), 32'd10, 32'd0, 32'hFFFFFFFF, 32'd0, 5'd17);
    send(enc(1'b1, 1'b0, 3'd5, OPIMM), 32'h80000010, 32'd0, 32'h00000404, 32'd0, 5'd18);
    send(enc(1'b0, 1'b0, 3'd5, OPIMM), 32'h80000010, 32'd0, 32'h00000004, 32'd0, 5'd19);
    send(enc(1'b0, 1'b0, 3'd2, OPIMM), 32'hFFFFFFF0, 32'd0, 32'h00000001, 32'd0, 5'd20);
    send(enc(1'b0, 1'b0, 3'd3, OPIMM), 32'h00000005, 32'd0, 32'hFFFFFFFF, 32'd0, 5'd21);
    send(enc(1'b0, 1'b0, 3'd0, 7'b0110111), 32'd1, 32'd2, 32'hABCDE000, 32'd0, 5'd22);
    send(enc(1'b0, 1'b0, 3'd0, 7'b0010111), 32'd1, 32'd2, 32'h00001000, 32'h00000400, 5'd23);
    send(enc(1'b0, 1'b0, 3'd2, 7'b0000011), 32'h2000, 32'd9, 32'h00000010, 32'd0, 5'd24);
    drain();
    chk("load_addr", cap_addr, 32'h2010);
    chk("load_data", cap_data, 32'd0);

    // 8 back-to-back ADDI
    for (int k = 0; k < 8; k++) begin
      send(enc(1'b0, 1'b0, 3'd0, OPIMM), 32'(k * 10), 32'd0, 32'(k + 1), 32'd0, 5'(k));
    end
    drain();
    chk("addi_last", cap_data, 32'd78);
    chk("addi_last_rd", cap_rd, 7);

`ifdef EXECUTE_MULDIV_EN
    send(enc(1'b0, 1'b1, 3'd1, OP), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 5'd25);
    drain();
    chk("mulh_m1", cap_data, 32'd0);
    send(enc(1'b0, 1'b1, 3'd5, OP), 32'd7, 32'd0, 32'd0, 32'd0, 5'd26);
    drain();
    chk("divu_zero", cap_data, 32'hFFFFFFFF);
    send(enc(1'b0, 1'b1, 3'd4, OP), 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd0, 5'd27);
    drain();
    chk("div_ovf", cap_data, 32'h80000000);
    send(enc(1'b0, 1'b1, 3'd6, OP), 32'hFFFFFFF9, 32'd2, 32'd0, 32'd0, 5'd28);
    drain();
    chk("rem_neg", cap_data, 32'hFFFFFFFF);
    send(enc(1'b0, 1'b1, 3'd0, OP), 32'd3, 32'hFFFFFFFB, 32'd0, 32'd0, 5'd29);
    drain();
    chk("mul_neg", cap_data, 32'hFFFFFFF1);
    send(enc(1'b0, 1'b1, 3'd2, OP), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 5'd30);
    drain();
    send(enc(1'b0, 1'b1, 3'd3, OP), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 5'd31);
    drain();
    send(enc(1'b0, 1'b1, 3'd4, OP), 32'hFFFFFF9C, 32'd7, 32'd0, 32'd0, 5'd1);
    drain();
    chk("div_neg", cap_data, 32'hFFFFFFF2);
    send(enc(1'b0, 1'b1, 3'd7, OP), 32'd100, 32'd7, 32'd0, 32'd0, 5'd2);
    drain();
    send(enc(1'b0, 1'b1, 3'd6, OP), 32'hFFFFFF9C, 32'd0, 32'd0, 32'd0, 5'd3);
    drain();
    send(enc(1'b0, 1'b0, 3'd0, OP), 32'd4, 32'd4, 32'd0, 32'd0, 5'd4);
    drain();
`else
    send(enc(1'b0, 1'b1, 3'd0, OP), 32'd3, 32'd5, 32'd0, 32'd0, 5'd25);
    drain();
    chk("mul_illegal_rw", cap_rw, 0);
    chk("mul_illegal_data", cap_data, 32'd0);
    chk("mul_illegal_rd", cap_rd, 25);
`endif
    idle(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
